led_frame_receiver: RTL
=======================

// Module: led_frame_receiver
// PURPOSE
//   Receive end of the serial LED-matrix link driven by LedController (sclk/sdata/slatch/sframe).
//   - Deserializes each row of pixel bits and writes the completed row into a row buffer.
//   - Flags the end of each frame and any malformed row.
//   - Serves as the display-side model in simulation and as the matrix-board front end in hardware.
//   - Default geometry is the 10x20 Tetris playfield.
// PARAMETERS
//   COLS   10   pixels per row = bits shifted per latch
//   ROWS   20   rows per frame; row_addr wraps at ROWS-1
//   ROW_W  $clog2(ROWS) (localparam, derived)   width of row_addr
// PORTS
//   clk        in   1      system clock; all logic on rising edge
//   reset_n    in   1      asynchronous, active-low reset
//   sclk       in   1      serial bit clock from transmitter; async to clk
//   sdata      in   1      serial pixel data, MSB (column COLS-1) first; sampled on sclk rise
//   slatch     in   1      rising edge ends a row
//   sframe     in   1      high at slatch rise marks row 0 (frame resync)
//   row_data   out  COLS   completed row; valid while row_we=1
//   row_addr   out  ROW_W  row index of row_data
//   row_we     out  1      one-cycle write strobe to row buffer
//   frame_done out  1      one-cycle pulse, concurrent with row_we for row ROWS-1
//   len_err    out  1      one-cycle pulse: latch seen with bit count != COLS
//   err_count  out  8      saturating count of len_err events (see CONFIGURATION)
// BEHAVIOUR
//   Reset
//     - All outputs 0; shift register, bit counter and row counter 0.
//     - Sync flops 0. Reset mid-row discards the partial row.
//   Input sync and edge detect
//     - sclk, sdata, slatch, sframe each pass through a 2-FF synchronizer.
//     - A 3rd register on sclk and slatch gives rise detection.
//     - Inputs must hold each level >= 2 clk periods.
//     - sdata must be stable 2 clk before and after each sclk rise.
//   Shift
//     - On sclk rise: shreg <= {shreg[COLS-2:0], sdata_s}.
//     - bitcnt increments, saturating at COLS+1 (overrun marker).
//   Latch (pin rise to strobe = 3 clk)
//     - bitcnt==COLS: row_we=1, row_data=shreg, row_addr=row.
//     - Otherwise: len_err=1 and no write; row is not advanced.
//     - Either way bitcnt<=0.
//   Row counter
//     - On a good latch: row<=row+1, and row==ROWS-1 wraps to 0 with frame_done=1.
//     - If sframe_s=1 at a good latch: written row_addr=0 and row<=1. A short frame is silently realigned.
//     - Overruns are reported via len_err only.
//   Simultaneous sclk rise and slatch rise (same synchronized cycle)
//     - The latch uses the pre-shift shreg and bitcnt.
//     - The new bit becomes bit 1 of the next row (bitcnt<=1).
//   Outputs are registered; row_data/row_addr hold their last value between strobes.
// CONFIGURATION
//   ERR_COUNT_EN defined
//     - err_count increments on each len_err, saturating at 255.
//     - Cleared only by reset.
//   ERR_COUNT_EN undefined
//     - No counter logic; err_count tied to 8'd0.
//     - Port list is unchanged.
// TESTING
//   1. Reset, then shift 10 bits 1011001110 and latch -> one row_we, row_data=10'b1011001110, row_addr=0, len_err=0.
//   2. Send 20 good rows, sframe high on the first -> row_addr 0..19, frame_done only with row 19; 21st row gets row_addr 0.
//   3. Shift 9 bits then latch -> len_err pulse, no row_we, row unchanged.
//      Shift 12 bits then latch -> len_err again; with ERR_COUNT_EN, err_count=2.
//   4. Rows 0..4 sent, then sframe-marked row -> row_addr=0, next row_addr=1.
//   5. sclk rise and slatch rise in the same cycle after 10 bits -> row written from the first 10 bits.
//      The following 9 bits plus latch give a good row (bitcnt started at 1).
//   6. Assert reset_n=0 after 5 bits, release, then send a clean 10-bit row -> correct row_data.
//      row_addr=0; all outputs 0 during reset.

Source files
------------

// File: rtl/led_frame_receiver.sv
// Receive end of the serial LED-matrix link: synchronizes sclk/sdata/slatch/sframe, deserializes rows
// and strobes them into a row buffer. Optional saturating error counter enabled by `define ERR_COUNT_EN.
module led_frame_receiver #(
  parameter int COLS = 10,
  parameter int ROWS = 20,
  localparam int ROW_W = $clog2(ROWS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sclk,
  input  logic             sdata,
  input  logic             slatch,
  input  logic             sframe,
  output logic [COLS-1:0]  row_data,
  output logic [ROW_W-1:0] row_addr,
  output logic             row_we,
  output logic             frame_done,
  output logic             len_err,
  output logic [7:0]       err_count
);

  localparam int CNT_W = $clog2(COLS + 2);

  logic sclk_p0, sclk_p1, sclk_p2;
  logic slatch_p0, slatch_p1, slatch_p2;
  logic sdata_p0, sdata_p1;
  logic sframe_p0, sframe_p1;

  logic [COLS-1:0]  shreg;
  logic [CNT_W-1:0] bitcnt;
  logic [ROW_W-1:0] row;
  logic [ROW_W-1:0] wr_addr;

  logic sclk_rise, latch_rise, good_latch, bad_latch;

  // Synchronizer stages; the third stage on sclk/slatch is only for rise detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_p0   <= 1'b0;
      sclk_p1   <= 1'b0;
      sclk_p2   <= 1'b0;
      slatch_p0 <= 1'b0;
      slatch_p1 <= 1'b0;
      slatch_p2 <= 1'b0;
      sdata_p0  <= 1'b0;
      sdata_p1  <= 1'b0;
      sframe_p0 <= 1'b0;
      sframe_p1 <= 1'b0;
    end else begin
      sclk_p0   <= sclk;
      sclk_p1   <= sclk_p0;
      sclk_p2   <= sclk_p1;
      slatch_p0 <= slatch;
      slatch_p1 <= slatch_p0;
      slatch_p2 <= slatch_p1;
      sdata_p0  <= sdata;
      sdata_p1  <= sdata_p0;
      sframe_p0 <= sframe;
      sframe_p1 <= sframe_p0;
    end
  end

  assign sclk_rise  = sclk_p1 & ~sclk_p2;
  assign latch_rise = slatch_p1 & ~slatch_p2;
  assign good_latch = latch_rise && (bitcnt == CNT_W'(COLS));
  assign bad_latch  = latch_rise && (bitcnt != CNT_W'(COLS));
  assign wr_addr    = sframe_p1 ? '0 : row;

  // Deserializer and row strobe; a latch coinciding with an sclk rise uses the pre-shift state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg      <= '0;
      bitcnt     <= '0;
      row        <= '0;
      row_data   <= '0;
      row_addr   <= '0;
      row_we     <= 1'b0;
      frame_done <= 1'b0;
      len_err    <= 1'b0;
    end else begin
      row_we     <= 1'b0;
      frame_done <= 1'b0;
      len_err    <= 1'b0;

      if (sclk_rise)
        shreg <= {shreg[COLS-2:0], sdata_p1};

      if (latch_rise) begin
        bitcnt <= sclk_rise ? CNT_W'(1) : '0;
      end else if (sclk_rise && bitcnt != CNT_W'(COLS + 1)) begin
        bitcnt <= bitcnt + 1'b1;
      end

      if (good_latch) begin
        row_we   <= 1'b1;
        row_data <= shreg;
        row_addr <= wr_addr;
        if (wr_addr == ROW_W'(ROWS - 1)) begin
          row        <= '0;
          frame_done <= 1'b1;
        end else begin
          row <= wr_addr + 1'b1;
        end
      end

      if (bad_latch)
        len_err <= 1'b1;
    end
  end

`ifdef ERR_COUNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      err_count <= 8'd0;
    else if (bad_latch && err_count != 8'd255)
      err_count <= err_count + 8'd1;
  end
`else
  assign err_count = 8'd0;
`endif

endmodule
